// File: rtl/iomem_periph_hub.sv
// ---------------------------------------------------------------------------
// iomem_periph_hub
//   PicoRV32 iomem slave hub. It decodes a window at BASE_ADDR into GPIO
//   registers, a request/acknowledge RNG port, a STATUS register and a user
//   RAM.
//
// Ports
//   clk, reset           sole clock; synchronous active-high reset
//   iomem_valid/ready    PicoRV32 iomem handshake
//   iomem_wstrb/addr/wdata/rdata
//   gpio_out             NUM_GPIO x 32-bit GPIO registers, reg i at [32i+31:32i]
//   rng_req/we/wdata     RNG request, held for the whole RNG_WAIT state
//   rng_ack/rdata        RNG acknowledge and read data
//   dbg_state            current FSM state, for checkers
//
// Handshake: a transfer is accepted on a rising edge where the FSM is in
// IDLE, iomem_valid=1, and the previous cycle was not a response. The master
// holds addr/wdata/wstrb stable until it sees iomem_ready. iomem_ready is a
// one-cycle pulse, and iomem_rdata is valid with it and held until the next
// response.
//
// Optional feature: define IOMEM_PERIPH_HUB_TIMEOUT_EN to bound RNG_WAIT to
// TIMEOUT_CYCLES cycles. An expired wait returns 32'hFFFF_FFFF and sets
// STATUS bit0.
// ---------------------------------------------------------------------------
module iomem_periph_hub #(
    parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
    parameter int          NUM_GPIO       = 1,
    parameter int          RAM_WORDS      = 256,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iomem_valid,
    output logic                    iomem_ready,
    input  logic [3:0]              iomem_wstrb,
    input  logic [31:0]             iomem_addr,
    input  logic [31:0]             iomem_wdata,
    output logic [31:0]             iomem_rdata,
    output logic [32*NUM_GPIO-1:0]  gpio_out,
    output logic                    rng_req,
    output logic                    rng_we,
    output logic [31:0]             rng_wdata,
    input  logic                    rng_ack,
    input  logic [31:0]             rng_rdata,
    output logic [1:0]              dbg_state
);

    localparam int AW = $clog2(RAM_WORDS);

    if (NUM_GPIO < 1 || NUM_GPIO > 8) begin : g_bad_num_gpio
        $error("iomem_periph_hub: NUM_GPIO must be 1..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("iomem_periph_hub: TIMEOUT_CYCLES must be 2..255");
    end

    typedef enum logic [1:0] {IDLE, RAM_RD, RNG_WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [31:0] gpio_q [NUM_GPIO];
    logic [31:0] mem [RAM_WORDS];
    logic [AW-1:0] ram_idx_q;
    logic [31:0] rdata_q;
    logic        skip_q;        // one-cycle valid blanking after a response
    logic        rng_we_q;
    logic [31:0] rng_wdata_q;
    logic [7:0]  unm_cnt_q;
    logic        timeout_bit;
    logic        rng_expire;

    // ---------------- decode ----------------
    logic [31:0] off;
    logic        hit_gpio, hit_rng, hit_stat, hit_ram, accept, is_wr;
    logic [2:0]  gidx;
    logic [31:0] mask, gpio_rd, status_word;

    always_comb begin
        off      = iomem_addr - BASE_ADDR;   // addresses below BASE wrap high
        hit_gpio = off < 32'(4 * NUM_GPIO);
        hit_rng  = off[31:2] == 30'h0000_0400;
        hit_stat = off[31:2] == 30'h0000_0401;
        hit_ram  = (off >= 32'h0000_2000) && (off < 32'(32'h2000 + 4 * RAM_WORDS));
        gidx     = off[4:2];
        accept   = (state == IDLE) && iomem_valid && !skip_q;
        is_wr    = |iomem_wstrb;
        mask     = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                    {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
        gpio_rd  = '0;
        for (int i = 0; i < NUM_GPIO; i++)
            if (gidx == i[2:0]) gpio_rd = gpio_q[i];
        status_word = {16'h0000, unm_cnt_q, 7'h00, timeout_bit};
    end

`ifdef IOMEM_PERIPH_HUB_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       timeout_q;
    assign timeout_bit = timeout_q;
    // Ack in the expiry cycle wins because RNG_WAIT checks rng_ack first.
    assign rng_expire  = (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == RNG_WAIT) to_cnt_q <= to_cnt_q + 8'd1;
            else                   to_cnt_q <= '0;
            if (accept && hit_stat && is_wr)
                timeout_q <= 1'b0;
            else if (state == RNG_WAIT && !rng_ack && rng_expire)
                timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_bit = 1'b0;
    assign rng_expire  = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (hit_ram)      state_nxt = RAM_RD;
                    else if (hit_rng) state_nxt = RNG_WAIT;
                    else              state_nxt = RESP;
                end
            end
            RAM_RD:   state_nxt = RESP;
            RNG_WAIT: if (rng_ack || rng_expire) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_GPIO; i++) gpio_q[i] <= '0;
            rdata_q     <= '0;
            skip_q      <= 1'b0;
            rng_we_q    <= 1'b0;
            rng_wdata_q <= '0;
            unm_cnt_q   <= '0;
            ram_idx_q   <= '0;
        end else begin
            skip_q <= (state == RESP);
            case (state)
                IDLE: if (accept) begin
                    if (hit_gpio) begin
                        rdata_q <= gpio_rd;  // pre-write value
                        for (int i = 0; i < NUM_GPIO; i++)
                            if (gidx == i[2:0])
                                gpio_q[i] <= (gpio_q[i] & ~mask) | (iomem_wdata & mask);
                    end else if (hit_stat) begin
                        rdata_q <= status_word;
                        if (is_wr) unm_cnt_q <= '0;
                    end else if (hit_rng) begin
                        rng_we_q    <= is_wr;
                        rng_wdata_q <= iomem_wdata & mask;
                    end else if (hit_ram) begin
                        ram_idx_q <= off[AW+1:2];
                    end else begin
                        rdata_q <= 32'hFFFF_FFFF;
                        if (unm_cnt_q != 8'hFF) unm_cnt_q <= unm_cnt_q + 8'd1;
                    end
                end
                RAM_RD: rdata_q <= mem[ram_idx_q];
                RNG_WAIT: begin
                    if (rng_ack || rng_expire) begin
                        if (rng_ack) rdata_q <= rng_we_q ? 32'h0 : rng_rdata;
                        else         rdata_q <= 32'hFFFF_FFFF;
                        rng_we_q    <= 1'b0;
                        rng_wdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM has no reset; write lands on the accept edge so RAM_RD sees it.
    always_ff @(posedge clk) begin
        if (!reset && accept && hit_ram && is_wr)
            for (int b = 0; b < 4; b++)
                if (iomem_wstrb[b]) mem[off[AW+1:2]][8*b +: 8] <= iomem_wdata[8*b +: 8];
    end

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_gpio_out
        assign gpio_out[32*g +: 32] = gpio_q[g];
    end

    // Gated by reset so a pending request/response is dropped immediately.
    assign iomem_ready = (state == RESP) && !reset;
    assign rng_req     = (state == RNG_WAIT) && !reset;
    assign rng_we      = rng_we_q;
    assign rng_wdata   = rng_wdata_q;
    assign iomem_rdata = rdata_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_iomem_periph_hub.sv
module tb_iomem_periph_hub;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = '0;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic [63:0] gpio_out;
    logic        rng_req, rng_we;
    logic [31:0] rng_wdata;
    logic        rng_ack = 1'b0;
    logic [31:0] rng_rdata = '0;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    iomem_periph_hub #(
        .BASE_ADDR(BASE), .NUM_GPIO(2), .RAM_WORDS(256), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .gpio_out(gpio_out),
        .rng_req(rng_req), .rng_we(rng_we), .rng_wdata(rng_wdata),
        .rng_ack(rng_ack), .rng_rdata(rng_rdata),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // RNG responder: counts request cycles of the current burst and acks
    // in request cycle ack_at (0 = never ack).
    int          ack_at = 0;
    int          req_cycles = 0;
    logic        prev_req = 1'b0;
    logic        seen_we = 1'b0;
    logic [31:0] seen_wdata = '0;

    always @(negedge clk) begin
        if (rng_req) begin
            req_cycles = prev_req ? req_cycles + 1 : 1;
            seen_we    = rng_we;
            seen_wdata = rng_wdata;
            rng_ack    = (ack_at != 0) && (req_cycles == ack_at);
        end else begin
            rng_ack = 1'b0;
        end
        prev_req = rng_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus transfer; returns read data and cycles from acceptance edge to ready.
    task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                            output logic [31:0] rd, output int lat);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        lat = 0;
        rd  = '0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (iomem_ready) break;
        end
        if (!iomem_ready) begin
            check("bus_timeout", 32'(iomem_ready), 32'd1);
        end else begin
            rd = iomem_rdata;
            iomem_valid = 1'b0;
            iomem_wstrb = '0;
            @(posedge clk);
            #1;
            check("ready_pulse", 32'(iomem_ready), 32'd0);
            @(posedge clk);
        end
    endtask

    logic [31:0] rd;
    int          lat;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_gpio_lo", gpio_out[31:0], 32'h0);
        check("rst_gpio_hi", gpio_out[63:32], 32'h0);
        check("rst_rng_req", 32'(rng_req), 32'd0);
        check("rst_rng_we", 32'(rng_we), 32'd0);
        check("rst_rng_wdata", rng_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // GPIO
        bus_xfer(BASE + 32'h4, 4'b0011, 32'h1234_5678, rd, lat);
        check("gpio1_wr_rdata", rd, 32'h0);
        check("gpio1_wr_lat", 32'(lat), 32'd1);
        check("gpio1_hi", gpio_out[63:32], 32'h0000_5678);
        check("gpio0_untouched", gpio_out[31:0], 32'h0);
        bus_xfer(BASE + 32'h4, 4'b1100, 32'hAABB_CCDD, rd, lat);
        check("gpio1_prewrite", rd, 32'h0000_5678);
        check("gpio1_hi2", gpio_out[63:32], 32'hAABB_5678);
        bus_xfer(BASE + 32'h4, 4'b0000, 32'hFFFF_FFFF, rd, lat);
        check("gpio1_rd", rd, 32'hAABB_5678);
        check("gpio1_rd_nowrite", gpio_out[63:32], 32'hAABB_5678);

        // RAM
        bus_xfer(BASE + 32'h2010, 4'b1111, 32'hCAFE_F00D, rd, lat);
        check("ram_wr_lat", 32'(lat), 32'd2);
        bus_xfer(BASE + 32'h2010, 4'b0000, 32'h0, rd, lat);
        check("ram_rd", rd, 32'hCAFE_F00D);
        check("ram_rd_lat", 32'(lat), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", iomem_rdata, 32'hCAFE_F00D);
        bus_xfer(BASE + 32'h2010, 4'b0001, 32'h0000_00EE, rd, lat);
        bus_xfer(BASE + 32'h2010, 4'b0000, 32'h0, rd, lat);
        check("ram_bytemask", rd, 32'hCAFE_F0EE);
        bus_xfer(BASE + 32'h23FC, 4'b1111, 32'h5A5A_5A5A, rd, lat);
        bus_xfer(BASE + 32'h23FC, 4'b0000, 32'h0, rd, lat);
        check("ram_last_word", rd, 32'h5A5A_5A5A);

        // Unmapped and STATUS
        for (int i = 0; i < 3; i++) begin
            bus_xfer(BASE + 32'h0800, 4'b0000, 32'h0, rd, lat);
            check("unmapped_rd", rd, 32'hFFFF_FFFF);
        end
        bus_xfer(BASE + 32'h1004, 4'b0000, 32'h0, rd, lat);
        check("status_cnt3", rd, 32'h0000_0300);
        check("status_lat", 32'(lat), 32'd1);
        bus_xfer(BASE + 32'h1004, 4'b1111, 32'h0, rd, lat);
        check("status_wr_prev", rd, 32'h0000_0300);
        bus_xfer(BASE + 32'h1004, 4'b0000, 32'h0, rd, lat);
        check("status_cleared", rd, 32'h0);
        bus_xfer(BASE + 32'h8, 4'b1111, 32'hFFFF_FFFF, rd, lat);
        check("gpio2_unmapped", rd, 32'hFFFF_FFFF);
        check("gpio_no_effect", gpio_out[63:32], 32'hAABB_5678);
        bus_xfer(BASE + 32'h2400, 4'b0000, 32'h0, rd, lat);
        check("ram_end_unmapped", rd, 32'hFFFF_FFFF);
        bus_xfer(BASE - 32'h4, 4'b0000, 32'h0, rd, lat);
        check("below_base", rd, 32'hFFFF_FFFF);
        bus_xfer(BASE + 32'h1004, 4'b0000, 32'h0, rd, lat);
        check("status_cnt_bounds", rd, 32'h0000_0300);

        // RNG read: ack in the 5th request cycle
        ack_at = 5;
        rng_rdata = 32'hA5A5_0001;
        bus_xfer(BASE + 32'h1000, 4'b0000, 32'h0, rd, lat);
        check("rng_rd_data", rd, 32'hA5A5_0001);
        check("rng_req_cycles", 32'(req_cycles), 32'd5);
        check("rng_rd_we", 32'(seen_we), 32'd0);
        check("rng_rd_lat", 32'(lat), 32'd6);
        check("rng_req_dropped", 32'(rng_req), 32'd0);

        // RNG write: unstrobed bytes zeroed
        ack_at = 2;
        bus_xfer(BASE + 32'h1000, 4'b0101, 32'h1122_3344, rd, lat);
        check("rng_wr_rdata", rd, 32'h0);
        check("rng_wr_we", 32'(seen_we), 32'd1);
        check("rng_wr_wdata", seen_wdata, 32'h0022_0044);
        check("rng_wr_cycles", 32'(req_cycles), 32'd2);

`ifdef IOMEM_PERIPH_HUB_TIMEOUT_EN
        bus_xfer(BASE + 32'h1004, 4'b1111, 32'h0, rd, lat);
        ack_at = 0;
        bus_xfer(BASE + 32'h1000, 4'b0000, 32'h0, rd, lat);
        check("to_rdata", rd, 32'hFFFF_FFFF);
        check("to_req_cycles", 32'(req_cycles), 32'd8);
        bus_xfer(BASE + 32'h1004, 4'b0000, 32'h0, rd, lat);
        check("to_status", rd, 32'h0000_0001);
`endif

        // Reset in the middle of an RNG wait
        ack_at = 0;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h1000;
        iomem_wstrb = 4'b0000;
        repeat (3) @(negedge clk);
        check("rng_pending", 32'(rng_req), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_drop_req", 32'(rng_req), 32'd0);
        @(posedge clk);
        #1;
        check("rst_no_ready", 32'(iomem_ready), 32'd0);
        check("rst_gpio_cleared", gpio_out[63:32], 32'h0);
        check("rst_rdata_cleared", iomem_rdata, 32'h0);
        @(negedge clk);
        iomem_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(iomem_ready), 32'd0);
        check("post_rst_req", 32'(rng_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/iomem_periph_hub.md
IOMEM_PERIPH_HUB -- requirements
Module: iomem_periph_hub

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0000, base of the decoded window.
REQ-002 SHALL have parameter NUM_GPIO, default 1, number of 32-bit GPIO registers (legal range 1..8).
REQ-003 SHALL have parameter RAM_WORDS, default 256, user RAM depth in 32-bit words (power of two, at most 1024).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, RNG wait limit (legal range 2..255).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have iomem_valid in 1, iomem_ready out 1, iomem_wstrb in 4, iomem_addr in 32, iomem_wdata in 32, iomem_rdata out 32; these form the PicoRV32 iomem slave bus.
REQ-008 SHALL have port gpio_out, output, 32*NUM_GPIO, GPIO register contents; register i occupies bits [32i+31:32i].
REQ-009 SHALL have rng_req out 1, rng_we out 1, rng_wdata out 32, rng_ack in 1, rng_rdata in 32; these form the RNG request/acknowledge port.

Function
REQ-010 Address map, offsets from BASE_ADDR: GPIO i at 0x0000+4i; RNG data at 0x1000; STATUS at 0x1004; RAM at 0x2000 to 0x2000+4*RAM_WORDS-1; all other addresses are unmapped.
REQ-011 FSM states SHALL be IDLE, RAM_RD, RNG_WAIT, RESP; the FSM accepts a transaction only in IDLE with iomem_valid=1.
REQ-012 iomem_ready SHALL be a single-cycle pulse; after RESP the FSM returns to IDLE and ignores iomem_valid for that one cycle.
REQ-013 GPIO/STATUS/unmapped: IDLE->RESP; iomem_ready SHALL assert 1 cycle after acceptance.
REQ-014 GPIO write SHALL update only bytes with wstrb set; iomem_rdata returns the pre-write value.
REQ-015 RAM: IDLE->RAM_RD->RESP; ready 2 cycles after acceptance; byte-masked write; read returns the stored word.
REQ-016 RNG: IDLE->RNG_WAIT; rng_req held high, rng_we=|wstrb, rng_wdata=wdata with unstrobed bytes zeroed, until the cycle rng_ack=1; then RESP with rdata=rng_rdata (reads) or 0 (writes).
REQ-017 rng_ack outside RNG_WAIT SHALL be ignored; rng_req SHALL drop the cycle after rng_ack.
REQ-018 Unmapped: writes SHALL have no effect; reads SHALL return 32'hFFFF_FFFF; STATUS[15:8] increments, saturating at 255.
REQ-019 STATUS read: bit0=timeout sticky, [15:8]=unmapped count, other bits 0; any write with nonzero wstrb clears bit0 and [15:8].
REQ-020 iomem_rdata SHALL hold its value until the next response.

Reset
REQ-021 reset high SHALL force IDLE, iomem_ready=0, iomem_rdata=0, gpio_out=0, rng_req=0, rng_we=0, rng_wdata=0, STATUS=0; RAM contents are undefined.
REQ-022 reset mid-transaction SHALL abort it with no ready pulse; a pending RNG request is dropped in the same cycle.

Configuration
REQ-023 Macro IOMEM_PERIPH_HUB_TIMEOUT_EN defined: a counter runs in RNG_WAIT; after TIMEOUT_CYCLES cycles without rng_ack -> RESP, rdata=32'hFFFF_FFFF, rng_req drops, STATUS bit0 set; ack in the same cycle as expiry counts as ack.
REQ-024 Macro undefined: RNG_WAIT waits indefinitely; no counter logic; STATUS bit0 reads 0.

Verification
REQ-025 Write 0x1234_5678 wstrb=4'b0011 to GPIO1 (NUM_GPIO=2) -> gpio_out[63:32]=0x0000_5678, ready 1 cycle later, rdata=0.
REQ-026 Write 0xCAFE_F00D to BASE+0x2010, then read it -> read returns 0xCAFE_F00D, ready 2 cycles after acceptance.
REQ-027 RNG read with rng_ack after 5 cycles, rng_rdata=0xA5A5_0001 -> rdata=0xA5A5_0001; rng_req high exactly 5 cycles.
REQ-028 Macro on, TIMEOUT_CYCLES=8, no ack -> ready after 8 cycles, rdata=0xFFFF_FFFF, STATUS read=0x0000_0001.
REQ-029 Three reads of BASE+0x0800 -> each returns 0xFFFF_FFFF; STATUS[15:8]=3; STATUS write clears it to 0.
REQ-030 reset asserted in RNG_WAIT -> rng_req=0 and no iomem_ready pulse next cycle; gpio_out=0.
